// File: rtl/cmsdk_mybusmatrix_addr_decoder.sv
//------------------------------------------------------------------------------
// cmsdk_mybusmatrix_addr_decoder
//
// AHB-Lite address decoder and slave-response multiplexer for three mapped
// regions plus a default slave, with capture of decode errors.
//
// Address phase : HADDR is matched against three base/mask pairs
//                 (priority S0 > S1 > S2). An address with no match selects
//                 the default slave. Exactly one HSEL_* is high at all times.
// Data phase    : the address-phase select is registered while HREADY=1.
//                 The registered select steers HREADYOUT/HRESP/HRDATA back
//                 from the addressed slave. The default slave returns no data.
// Error capture : the first cycle of a two-cycle ERROR from the default slave
//                 sets a sticky flag, records the transfer address, and bumps
//                 a saturating 8-bit count. ERRCLR clears the flag and count.
//
// Ports
//   HCLK, HRESETn                     clock, asynchronous active-low reset
//   HADDR, HTRANS, HREADY             master address phase / bus ready
//   HSEL_S0/S1/S2, HSEL_DEF           address-phase slave selects
//   HREADYOUT_*, HRESP_*, HRDATA_*    slave responses
//   HREADYOUT, HRESP, HRDATA          multiplexed response to the master
//   ERRCLR                            synchronous clear of the error capture
//   ERRFLAG, ERRADDR, ERRCNT          decode-error capture state
//------------------------------------------------------------------------------
module cmsdk_mybusmatrix_addr_decoder #(
    parameter logic [31:0] S0_BASE = 32'h0000_0000,
    parameter logic [31:0] S0_MASK = 32'hE000_0000,
    parameter logic [31:0] S1_BASE = 32'h2000_0000,
    parameter logic [31:0] S1_MASK = 32'hE000_0000,
    parameter logic [31:0] S2_BASE = 32'h4000_0000,
    parameter logic [31:0] S2_MASK = 32'hF000_0000
) (
    input  logic        HCLK,
    input  logic        HRESETn,

    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HREADY,

    output logic        HSEL_S0,
    output logic        HSEL_S1,
    output logic        HSEL_S2,
    output logic        HSEL_DEF,

    input  logic        HREADYOUT_S0,
    input  logic        HREADYOUT_S1,
    input  logic        HREADYOUT_S2,
    input  logic        HREADYOUT_DEF,

    input  logic [1:0]  HRESP_S0,
    input  logic [1:0]  HRESP_S1,
    input  logic [1:0]  HRESP_S2,
    input  logic [1:0]  HRESP_DEF,

    input  logic [31:0] HRDATA_S0,
    input  logic [31:0] HRDATA_S1,
    input  logic [31:0] HRDATA_S2,

    output logic        HREADYOUT,
    output logic [1:0]  HRESP,
    output logic [31:0] HRDATA,

    input  logic        ERRCLR,
    output logic        ERRFLAG,
    output logic [31:0] ERRADDR,
    output logic [7:0]  ERRCNT
);

    // One-hot slave select, bit order S0, S1, S2, DEF.
    typedef enum logic [3:0] {
        SEL_S0  = 4'b0001,
        SEL_S1  = 4'b0010,
        SEL_S2  = 4'b0100,
        SEL_DEF = 4'b1000
    } sel_t;

    localparam logic [1:0] RESP_ERROR = 2'b01;

    sel_t        asel;        // address-phase select
    sel_t        dsel;        // data-phase select
    logic        hit_s0;
    logic        hit_s1;
    logic        hit_s2;
    logic        trans_active;
    logic        err_event;
    logic [31:0] haddr_q;

    //--------------------------------------------------------------------------
    // Address-phase decode
    //--------------------------------------------------------------------------
    assign hit_s0 = ((HADDR & S0_MASK) == S0_BASE);
    assign hit_s1 = ((HADDR & S1_MASK) == S1_BASE);
    assign hit_s2 = ((HADDR & S2_MASK) == S2_BASE);

    // Selects depend only on HADDR so the slave sees a stable one-hot select
    // regardless of transfer type; IDLE/BUSY to unmapped space still lands on
    // the default slave, which answers OKAY for those.
    always_comb begin
        asel = SEL_DEF;
        if (hit_s0) begin
            asel = SEL_S0;
        end else if (hit_s1) begin
            asel = SEL_S1;
        end else if (hit_s2) begin
            asel = SEL_S2;
        end
    end

    assign HSEL_S0  = (asel == SEL_S0);
    assign HSEL_S1  = (asel == SEL_S1);
    assign HSEL_S2  = (asel == SEL_S2);
    assign HSEL_DEF = (asel == SEL_DEF);

    //--------------------------------------------------------------------------
    // Data-phase select: advances only when the bus completes a transfer
    //--------------------------------------------------------------------------
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dsel <= SEL_DEF;
        end else if (HREADY) begin
            dsel <= asel;
        end
    end

    //--------------------------------------------------------------------------
    // Response multiplexer
    //--------------------------------------------------------------------------
    always_comb begin
        HREADYOUT = HREADYOUT_DEF;
        HRESP     = HRESP_DEF;
        HRDATA    = '0;
        case (dsel)
            SEL_S0: begin
                HREADYOUT = HREADYOUT_S0;
                HRESP     = HRESP_S0;
                HRDATA    = HRDATA_S0;
            end
            SEL_S1: begin
                HREADYOUT = HREADYOUT_S1;
                HRESP     = HRESP_S1;
                HRDATA    = HRDATA_S1;
            end
            SEL_S2: begin
                HREADYOUT = HREADYOUT_S2;
                HRESP     = HRESP_S2;
                HRDATA    = HRDATA_S2;
            end
            default: begin
                HREADYOUT = HREADYOUT_DEF;
                HRESP     = HRESP_DEF;
                HRDATA    = '0;
            end
        endcase
    end

    //--------------------------------------------------------------------------
    // Transfer address register (NONSEQ/SEQ only)
    //--------------------------------------------------------------------------
    assign trans_active = (HTRANS == 2'b10) || (HTRANS == 2'b11);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            haddr_q <= '0;
        end else if (HREADY && trans_active) begin
            haddr_q <= HADDR;
        end
    end

    //--------------------------------------------------------------------------
    // Decode-error capture
    //--------------------------------------------------------------------------
    // Only the first (HREADYOUT low) cycle of the two-cycle ERROR response
    // qualifies, so each erroring transfer counts exactly once.
    assign err_event = (dsel == SEL_DEF) && (HRESP_DEF == RESP_ERROR) && !HREADYOUT_DEF;

    // A clear coinciding with an event restarts the count at one rather than
    // losing the new error.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            ERRFLAG <= 1'b0;
            ERRADDR <= '0;
            ERRCNT  <= '0;
        end else if (err_event) begin
            ERRFLAG <= 1'b1;
            ERRADDR <= haddr_q;
            if (ERRCLR) begin
                ERRCNT <= 8'd1;
            end else if (ERRCNT != 8'hFF) begin
                ERRCNT <= ERRCNT + 8'd1;
            end
        end else if (ERRCLR) begin
            ERRFLAG <= 1'b0;
            ERRCNT  <= '0;
        end
    end

endmodule

// File: tb/tb_cmsdk_mybusmatrix_addr_decoder.sv
//------------------------------------------------------------------------------
// Testbench for cmsdk_mybusmatrix_addr_decoder.
// A reference model tracks the data-phase slave index, the captured transfer
// address and the error capture state as plain integers; a compare process
// checks every DUT output against it on each falling clock edge. Directed
// sequences pin the model with literal expectations, then a randomized phase
// exercises arbitrary input combinations including asynchronous resets.
//------------------------------------------------------------------------------
module tb_cmsdk_mybusmatrix_addr_decoder;

    localparam logic [31:0] RBASE [3] = '{32'h0000_0000, 32'h2000_0000, 32'h4000_0000};
    localparam logic [31:0] RMASK [3] = '{32'hE000_0000, 32'hE000_0000, 32'hF000_0000};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] haddr = '0;
    logic [1:0]  htrans = '0;
    logic        hready;
    logic        fb_mode = 1'b1;
    logic        rnd_ready = 1'b1;
    logic        hsel_s0, hsel_s1, hsel_s2, hsel_def;
    logic        hrdy_s0 = 1'b1, hrdy_s1 = 1'b1, hrdy_s2 = 1'b1, hrdy_def = 1'b1;
    logic [1:0]  hresp_s0 = '0, hresp_s1 = '0, hresp_s2 = '0, hresp_def = '0;
    logic [31:0] hrdata_s0 = '0, hrdata_s1 = '0, hrdata_s2 = '0;
    logic        hreadyout;
    logic [1:0]  hresp;
    logic [31:0] hrdata;
    logic        errclr = 1'b0;
    logic        errflag;
    logic [31:0] erraddr;
    logic [7:0]  errcnt;

    int          n_tests = 0;
    int          n_fail = 0;
    logic        chk_en = 1'b0;

    // Reference model state
    int          m_slave = 3;
    logic [31:0] m_haddr = '0;
    logic        m_flag = 1'b0;
    logic [31:0] m_eaddr = '0;
    int          m_cnt = 0;

    // Scratch for the compare process
    logic [3:0]  c_rdy;
    logic [1:0]  c_rsp [4];
    logic [31:0] c_dat [4];

    always #5 clk = ~clk;

    // In directed mode the bus ready is this block's own HREADYOUT fed back.
    always_comb hready = fb_mode ? hreadyout : rnd_ready;

    cmsdk_mybusmatrix_addr_decoder #(
        .S0_BASE(32'h0000_0000), .S0_MASK(32'hE000_0000),
        .S1_BASE(32'h2000_0000), .S1_MASK(32'hE000_0000),
        .S2_BASE(32'h4000_0000), .S2_MASK(32'hF000_0000)
    ) dut (
        .HCLK(clk), .HRESETn(rst_n),
        .HADDR(haddr), .HTRANS(htrans), .HREADY(hready),
        .HSEL_S0(hsel_s0), .HSEL_S1(hsel_s1), .HSEL_S2(hsel_s2), .HSEL_DEF(hsel_def),
        .HREADYOUT_S0(hrdy_s0), .HREADYOUT_S1(hrdy_s1),
        .HREADYOUT_S2(hrdy_s2), .HREADYOUT_DEF(hrdy_def),
        .HRESP_S0(hresp_s0), .HRESP_S1(hresp_s1),
        .HRESP_S2(hresp_s2), .HRESP_DEF(hresp_def),
        .HRDATA_S0(hrdata_s0), .HRDATA_S1(hrdata_s1), .HRDATA_S2(hrdata_s2),
        .HREADYOUT(hreadyout), .HRESP(hresp), .HRDATA(hrdata),
        .ERRCLR(errclr), .ERRFLAG(errflag), .ERRADDR(erraddr), .ERRCNT(errcnt)
    );

    function automatic int region_of(input logic [31:0] a);
        for (int i = 0; i < 3; i++) begin
            if ((a & RMASK[i]) == RBASE[i]) return i;
        end
        return 3;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: state advances on the rising edge, resets asynchronously.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_slave = 3;
            m_haddr = '0;
            m_flag  = 1'b0;
            m_eaddr = '0;
            m_cnt   = 0;
        end else begin
            if (m_slave == 3 && hresp_def == 2'b01 && !hrdy_def) begin
                m_flag  = 1'b1;
                m_eaddr = m_haddr;
                m_cnt   = errclr ? 1 : ((m_cnt < 255) ? m_cnt + 1 : 255);
            end else if (errclr) begin
                m_flag = 1'b0;
                m_cnt  = 0;
            end
            if (hready) m_slave = region_of(haddr);
            if (hready && htrans[1]) m_haddr = haddr;
        end
    end

    // Compare process
    always @(negedge clk) begin
        if (chk_en) begin
            c_rdy = {hrdy_def, hrdy_s2, hrdy_s1, hrdy_s0};
            c_rsp[0] = hresp_s0; c_rsp[1] = hresp_s1; c_rsp[2] = hresp_s2; c_rsp[3] = hresp_def;
            c_dat[0] = hrdata_s0; c_dat[1] = hrdata_s1; c_dat[2] = hrdata_s2; c_dat[3] = '0;
            chk("hsel", {28'd0, hsel_def, hsel_s2, hsel_s1, hsel_s0}, 32'd1 << region_of(haddr));
            chk("hreadyout", {31'd0, hreadyout}, {31'd0, c_rdy[m_slave]});
            chk("hresp", {30'd0, hresp}, {30'd0, c_rsp[m_slave]});
            chk("hrdata", hrdata, c_dat[m_slave]);
            chk("errflag", {31'd0, errflag}, {31'd0, m_flag});
            chk("erraddr", erraddr, m_eaddr);
            chk("errcnt", {24'd0, errcnt}, m_cnt);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One erroring NONSEQ to an unmapped address with a two-cycle default-slave
    // ERROR; clr is asserted during the first (counting) response cycle.
    task automatic err_xfer(input logic [31:0] addr, input logic clr);
        step(); haddr = addr; htrans = 2'b10; hrdy_def = 1'b1; hresp_def = 2'b00;
        step(); haddr = '0; htrans = 2'b00; hrdy_def = 1'b0; hresp_def = 2'b01; errclr = clr;
        step(); errclr = 1'b0; hrdy_def = 1'b1; hresp_def = 2'b01;
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_errflag", {31'd0, errflag}, 32'd0);
        chk("rst_errcnt", {24'd0, errcnt}, 32'd0);
        chk("rst_erraddr", erraddr, 32'd0);
        chk("rst_hreadyout", {31'd0, hreadyout}, 32'd1);
        chk("rst_hresp", {30'd0, hresp}, 32'd0);
        chk("rst_hrdata", hrdata, 32'd0);
        rst_n = 1'b1;
        chk_en = 1'b1;

        // S1 read
        step(); haddr = 32'h2000_0010; htrans = 2'b10; hrdata_s1 = 32'hA5A5_0001;
        #1;
        chk("s1_hsel_s1", {31'd0, hsel_s1}, 32'd1);
        chk("s1_hsel_def", {31'd0, hsel_def}, 32'd0);
        step(); haddr = '0; htrans = 2'b00;
        #1;
        chk("s1_hrdata", hrdata, 32'hA5A5_0001);
        chk("s1_hresp", {30'd0, hresp}, 32'd0);

        // Unmapped NONSEQ -> default ERROR
        step(); haddr = 32'h8000_0000; htrans = 2'b10;
        #1;
        chk("err_hsel_def", {31'd0, hsel_def}, 32'd1);
        step(); haddr = '0; htrans = 2'b00; hrdy_def = 1'b0; hresp_def = 2'b01;
        #1;
        chk("err_c1_ready", {31'd0, hreadyout}, 32'd0);
        chk("err_c1_resp", {30'd0, hresp}, 32'd1);
        chk("err_c1_flag", {31'd0, errflag}, 32'd0);
        step(); hrdy_def = 1'b1;
        #1;
        chk("err_c2_ready", {31'd0, hreadyout}, 32'd1);
        chk("err_c2_resp", {30'd0, hresp}, 32'd1);
        chk("err_flag", {31'd0, errflag}, 32'd1);
        chk("err_addr", erraddr, 32'h8000_0000);
        chk("err_cnt", {24'd0, errcnt}, 32'd1);
        step(); hresp_def = 2'b00;

        // IDLE to unmapped address: OKAY, no count
        step(); haddr = 32'h8000_0000; htrans = 2'b00;
        step();
        #1;
        chk("idle_ready", {31'd0, hreadyout}, 32'd1);
        chk("idle_resp", {30'd0, hresp}, 32'd0);
        chk("idle_cnt", {24'd0, errcnt}, 32'd1);

        // S0 wait states while the address moves to S2
        step(); haddr = 32'h0000_0100; htrans = 2'b10;
        hrdata_s0 = 32'h5050_0000; hrdata_s2 = 32'h2222_2222;
        step(); hrdy_s0 = 1'b0; haddr = 32'h4000_0000; htrans = 2'b10;
        for (int w = 0; w < 3; w++) begin
            #1;
            chk("wait_ready", {31'd0, hreadyout}, 32'd0);
            chk("wait_hrdata_s0", hrdata, 32'h5050_0000);
            if (w < 2) step();
        end
        step(); hrdy_s0 = 1'b1;
        #1;
        chk("wait_done_hrdata_s0", hrdata, 32'h5050_0000);
        step(); htrans = 2'b00; haddr = '0;
        #1;
        chk("wait_then_s2", hrdata, 32'h2222_2222);

        // Clear coinciding with an error event
        err_xfer(32'hA000_0000, 1'b0);
        #1;
        chk("cnt_two", {24'd0, errcnt}, 32'd2);
        err_xfer(32'hC000_0000, 1'b1);
        #1;
        chk("clr_evt_cnt", {24'd0, errcnt}, 32'd1);
        chk("clr_evt_flag", {31'd0, errflag}, 32'd1);
        chk("clr_evt_addr", erraddr, 32'hC000_0000);
        step(); hresp_def = 2'b00; errclr = 1'b1;
        step(); errclr = 1'b0;
        #1;
        chk("clr_flag", {31'd0, errflag}, 32'd0);
        chk("clr_cnt", {24'd0, errcnt}, 32'd0);
        chk("clr_addr_held", erraddr, 32'hC000_0000);

        // Saturation
        for (int i = 0; i < 300; i++) err_xfer(32'h8000_0000 + 32'(i * 4), 1'b0);
        #1;
        chk("sat_cnt", {24'd0, errcnt}, 32'h0000_00FF);
        chk("sat_addr", erraddr, 32'h8000_04AC);
        step(); hresp_def = 2'b00;

        // Reset in the middle of an ERROR response
        step(); haddr = 32'h8000_0000; htrans = 2'b10;
        step(); haddr = '0; htrans = 2'b00; hrdy_def = 1'b0; hresp_def = 2'b01;
        #2; rst_n = 1'b0;
        #1;
        chk("rstmid_flag", {31'd0, errflag}, 32'd0);
        chk("rstmid_cnt", {24'd0, errcnt}, 32'd0);
        chk("rstmid_addr", erraddr, 32'd0);
        step();
        chk("rstmid_nocapture", {31'd0, errflag}, 32'd0);
        hrdy_def = 1'b1; hresp_def = 2'b00;
        #1;
        chk("rstmid_ready", {31'd0, hreadyout}, 32'd1);
        chk("rstmid_resp", {30'd0, hresp}, 32'd0);
        rst_n = 1'b1;

        // Reset while S1 owns the data phase
        step(); haddr = 32'h2000_0000; htrans = 2'b10;
        step(); haddr = '0; htrans = 2'b00;
        #1;
        chk("s1_pre_rst", hrdata, 32'hA5A5_0001);
        rst_n = 1'b0;
        #1;
        chk("s1_rst_hrdata", hrdata, 32'd0);
        step(); rst_n = 1'b1;

        // Randomized phase
        fb_mode = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            step();
            haddr     = $urandom;
            htrans    = 2'($urandom);
            rnd_ready = ($urandom_range(0, 3) != 0);
            hrdy_s0   = ($urandom_range(0, 3) != 0);
            hrdy_s1   = ($urandom_range(0, 3) != 0);
            hrdy_s2   = ($urandom_range(0, 3) != 0);
            hrdy_def  = ($urandom_range(0, 1) != 0);
            hresp_s0  = 2'($urandom_range(0, 1));
            hresp_s1  = 2'($urandom_range(0, 1));
            hresp_s2  = 2'($urandom_range(0, 1));
            hresp_def = 2'($urandom_range(0, 1));
            hrdata_s0 = $urandom;
            hrdata_s1 = $urandom;
            hrdata_s2 = $urandom;
            errclr    = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 299) == 0) begin
                #2; rst_n = 1'b0;
                step(); rst_n = 1'b1;
            end
        end

        step();
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
